// File: rtl/counter_checker_if.sv
// Observed up/down counter signals as seen by an in-circuit checker.
// master = the counter side that drives them, slave = the checker side.
interface counter_checker_if #(
  parameter int unsigned WIDTH = 8
);
  logic             dut_rst;
  logic             enable;
  logic             direction;
  logic [WIDTH-1:0] count_in;

  modport master (output dut_rst, enable, direction, count_in);
  modport slave  (input  dut_rst, enable, direction, count_in);
endinterface

// File: rtl/counter_checker.sv
// In-circuit checker for an up/down counter. It predicts each next count from the
// observed inputs and reports mismatches, a sticky error flag, counters and the first failure.
module counter_checker #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MAX_ERR = 15
) (
  input  logic                clk,
  input  logic                rst,
  counter_checker_if.slave    obs,
  output logic                locked,
  output logic                mismatch,
  output logic                err,
  output logic [7:0]          err_count,
  output logic [15:0]         check_count,
  output logic [WIDTH-1:0]    first_exp,
  output logic [WIDTH-1:0]    first_got
);

  localparam int unsigned ERR_W = 8;
  localparam int unsigned CHK_W = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_TRACK = 2'd2,
    S_FAIL  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   exp_q, exp_d;
  logic [WIDTH-1:0]   pred_c;
  logic [ERR_W-1:0]   err_inc_c;
  logic               locked_d, mismatch_d, err_d;
  logic [ERR_W-1:0]   err_count_d;
  logic [CHK_W-1:0]   check_count_d;
  logic [WIDTH-1:0]   first_exp_d, first_got_d;

  // Reference counter: reset beats enable; wrap is natural modulo 2^WIDTH
  always_comb begin
    pred_c = obs.count_in;
    if (obs.dut_rst) begin
      pred_c = '0;
    end else if (obs.enable) begin
      pred_c = obs.direction ? (obs.count_in + WIDTH'(1)) : (obs.count_in - WIDTH'(1));
    end
  end

  assign err_inc_c = err_count + ERR_W'(1);

  // Next-state and next-output logic
  always_comb begin
    state_d       = state_q;
    exp_d         = exp_q;
    mismatch_d    = 1'b0;
    err_d         = err;
    err_count_d   = err_count;
    check_count_d = check_count;
    first_exp_d   = first_exp;
    first_got_d   = first_got;

    case (state_q)
      S_IDLE: begin
        state_d = S_PRIME;
      end
      S_PRIME: begin
        exp_d   = pred_c;
        state_d = S_TRACK;
      end
      S_TRACK: begin
        exp_d = pred_c;
        if (check_count != {CHK_W{1'b1}}) begin
          check_count_d = check_count + CHK_W'(1);
        end
        if (obs.count_in != exp_q) begin
          mismatch_d  = 1'b1;
          err_d       = 1'b1;
          err_count_d = err_inc_c;
          if (!err) begin
            first_exp_d = exp_q;
            first_got_d = obs.count_in;
          end
          if (err_inc_c == ERR_W'(MAX_ERR)) begin
            state_d = S_FAIL;
          end
        end
      end
      S_FAIL: begin
        state_d = S_FAIL;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    locked_d = (state_d == S_TRACK);
  end

  // State and output registers; checker reset overrides everything
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      exp_q       <= '0;
      locked      <= 1'b0;
      mismatch    <= 1'b0;
      err         <= 1'b0;
      err_count   <= '0;
      check_count <= '0;
      first_exp   <= '0;
      first_got   <= '0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      locked      <= locked_d;
      mismatch    <= mismatch_d;
      err         <= err_d;
      err_count   <= err_count_d;
      check_count <= check_count_d;
      first_exp   <= first_exp_d;
      first_got   <= first_got_d;
    end
  end

endmodule

// File: doc/counter_checker.md
# counter_checker

Synthesizable in-circuit checker for the 8-bit up/down counter. It sits beside the counter in the design and observes the counter's control inputs and count output, so it is the consuming end of the counter's interface. Each cycle it predicts the next count and flags any deviation. It reports sticky error status, an error count and the first failing expected/observed pair, so on-chip self-test gives the same verdict as the simulation bench.

## Interface
- `WIDTH`, default 8: width of the observed count.
- `MAX_ERR`, default 15: the error count at which checking stops (FAIL state). Must be ≥1 and fit in 8 bits.
- `clk` (input, 1): checker clock, the same clock as the counter.
- `rst` (input, 1): checker reset, synchronous, active-low. It resets the checker only and is independent of `dut_rst`.
- `dut_rst` (input, 1): observed counter reset, active-high.
- `enable` (input, 1): observed counter enable.
- `direction` (input, 1): observed counter direction. 1 means up, 0 means down.
- `count_in` (input, WIDTH): observed counter output.
- `locked` (output, 1): high while the checker is in TRACK.
- `mismatch` (output, 1): one-cycle pulse for each detected error.
- `err` (output, 1): sticky error flag.
- `err_count` (output, 8): number of detected errors. It stops at MAX_ERR.
- `check_count` (output, 16): number of comparisons performed. It saturates at 16'hFFFF.
- `first_exp` (output, WIDTH): expected value at the first error.
- `first_got` (output, WIDTH): observed value at the first error.

## Operation
- Reference model of the counter, evaluated at each rising edge:
  - `dut_rst`=1: next count = 0.
  - Otherwise, `enable`=1: next count = count ± 1 (+ when `direction`=1, − when 0), mod 2^WIDTH.
  - Otherwise: next count = count (hold).
- Prediction register: at every edge in PRIME or TRACK the checker stores `exp_q` = model(`count_in`, `dut_rst`, `enable`, `direction`), computed from the values sampled at that edge.
- Because the prediction always uses the observed `count_in`, the checker resynchronises after an error. One glitch produces at most two mismatches: the bad value itself, and the step away from it.
- State machine (2-bit):
  - IDLE: entered on `rst`=0. Next edge goes to PRIME.
  - PRIME: loads `exp_q` and performs no comparison. Next edge goes to TRACK.
  - TRACK: at each edge, compares `count_in` with `exp_q`, increments `check_count` and reloads `exp_q`.
    - On inequality: `mismatch`=1, `err`=1, `err_count`+1.
    - If `err` was 0 before this error, also capture `first_exp`=`exp_q` and `first_got`=`count_in`.
    - If the incremented `err_count` equals MAX_ERR, go to FAIL.
  - FAIL: all outputs frozen, `mismatch`=0, `locked`=0. The only exit is `rst`=0.
- Boundary cases:
  - Wrap: up from 2^WIDTH−1 is predicted as 0; down from 0 is predicted as 2^WIDTH−1. Neither is an error.
  - `dut_rst`=1 with `enable`=1: reset wins, predicted 0.
  - `dut_rst` held for several cycles: predicted 0 each cycle.
  - Direction changes take effect on the edge where they are sampled. There is no turnaround penalty.
  - `rst`=0 mid-run: on the next edge every output clears and the state returns to IDLE. `rst` has priority over every other input.
- Reset values: `locked`=0, `mismatch`=0, `err`=0, `err_count`=0, `check_count`=0, `first_exp`=0, `first_got`=0, `exp_q`=0, state=IDLE.

## Timing
- All outputs are registered and there are no combinational paths from input to output.
- A wrong `count_in` present before edge E drives `mismatch`=1 for the cycle following E. `err`, `err_count` and `first_*` update at E.
- After `rst` is released at edge R:
  - IDLE→PRIME at R+1.
  - PRIME→TRACK at R+2, which is also the first `exp_q` load.
  - First comparison at R+3.
  - `locked` rises at R+2.
- `check_count` increments exactly once per edge spent in TRACK.
- `mismatch` never stays high for two cycles unless two consecutive comparisons both fail.

## Test plan
- Up count, `enable`=1, `direction`=1, WIDTH=8, 40 cycles after lock → `err`=0, `err_count`=0, `check_count`=40, `mismatch` never asserted.
- Wrap both ways: counter preset to 8'hFE counting up for 4 cycles, then `direction`=0 through 0→8'hFF → no errors. Independently, a model that stops at 255 (fails to wrap) → `err`=1, `first_exp`=0, `first_got`=255.
- Hold and reset: `enable`=0 for 5 cycles with the count steady at 30 → no error. Then `dut_rst`=1 together with `enable`=1 at count 30 → prediction 0, no error.
- Injected fault: force `count_in`=8'h55 for one cycle where 8'h12 is expected → `mismatch` pulses at that check and again one cycle later, `err_count`=2, `first_exp`=8'h12, `first_got`=8'h55. Normal counting afterwards adds no further errors.
- Saturation: MAX_ERR=3 with a count stuck at 7 while enabled → `err_count` reaches 3, state goes to FAIL, `locked`=0. Further stimulus changes nothing.
- Checker reset mid-run: `rst`=0 for one edge with `err`=1 → all outputs 0 on the next cycle, and `locked` returns 2 edges after `rst`=1.
